// File: rtl/mul_pkg.sv
// Shared types for the multiply stage: the decode-side request, the writeback
// request it produces, and the per-stage pipeline payload.
package mul_pkg;

    localparam int MUL_STAGES_DEFAULT = 4;
    localparam int XLEN               = 32;
    localparam int ROB_ID_W           = 6;
    localparam int REG_ADDR_W         = 5;

    typedef logic [ROB_ID_W-1:0]   rob_id_t;
    typedef logic [XLEN-1:0]       reg_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        rob_id_t   instr_id;
        reg_addr_t rd;
        reg_data_t pc;
        reg_data_t src1_data;
        reg_data_t src2_data;
        rob_id_t   src1_id;
        rob_id_t   src2_id;
        logic      src1_ready;
        logic      src2_ready;
    } mul_request_t;

    typedef struct packed {
        rob_id_t    instr_id;
        reg_addr_t  rd;
        reg_data_t  pc;
        reg_data_t  data;
        logic       xcpt_valid;
        logic [3:0] xcpt_cause;
    } writeback_request_t;

    typedef struct packed {
        rob_id_t   instr_id;
        reg_addr_t rd;
        reg_data_t pc;
    } mul_meta_t;

    // acc holds the low-half partial product once it has been formed (M2 on).
    typedef struct packed {
        mul_meta_t meta;
        reg_data_t a;
        reg_data_t b;
        reg_data_t acc;
    } pipe_entry_t;

    // a * b[15:0], low 32 bits.
    function automatic reg_data_t mul_lo_part(input reg_data_t a, input reg_data_t b);
        return a * {16'b0, b[15:0]};
    endfunction

    // (a * b[31:16]) << 16, low 32 bits. lo + hi == low 32 bits of a*b,
    // which is the same for signed and unsigned operands.
    function automatic reg_data_t mul_hi_part(input reg_data_t a, input reg_data_t b);
        return (a * {16'b0, b[31:16]}) << 16;
    endfunction

endpackage

// File: rtl/mul_if.sv
// Decode / bypass / writeback signals of the multiply stage.
// Handshake: a request transfers on a clock edge where req_valid && mul_ready;
// req_info must be stable while req_valid is high; mul_ready may depend on
// flush and on the wait slot but never on req_valid. mul_req_valid is a
// one-cycle pulse with no back-pressure; bypass hits answer the ids in the
// same cycle.
interface mul_if;
    import mul_pkg::*;

    logic               req_valid;
    mul_request_t       req_info;
    logic               mul_ready;
    rob_id_t            mul_src1_id;
    rob_id_t            mul_src2_id;
    logic               mul_src1_hit;
    logic               mul_src2_hit;
    reg_data_t          mul_src1_data;
    reg_data_t          mul_src2_data;
    logic               mul_req_valid;
    writeback_request_t mul_req_info;

    modport slave (
        input  req_valid, req_info, mul_src1_hit, mul_src2_hit,
               mul_src1_data, mul_src2_data,
        output mul_ready, mul_src1_id, mul_src2_id, mul_req_valid, mul_req_info
    );

    modport master (
        output req_valid, req_info, mul_src1_hit, mul_src2_hit,
               mul_src1_data, mul_src2_data,
        input  mul_ready, mul_src1_id, mul_src2_id, mul_req_valid, mul_req_info
    );

endinterface

// File: rtl/mul_pipe.sv
// Fixed-depth multiply pipeline M1..M<STAGES>. Never stalls; flush and reset
// clear every valid. The low-half partial product is formed between M1 and
// M2 and the high half is added at the output.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int STAGES = MUL_STAGES_DEFAULT  // legal range 1..8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    input  mul_meta_t          in_meta,
    input  reg_data_t          in_a,
    input  reg_data_t          in_b,
    output logic               out_valid,
    output writeback_request_t out_info
);

    logic [STAGES-1:0] stage_valid;
    pipe_entry_t       stage_q [STAGES];
    pipe_entry_t       stage_d [STAGES];
    pipe_entry_t       last;
    reg_data_t         product;

    // Valid chain: advances every cycle, cleared by reset or flush.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                stage_valid[k] <= stage_valid[k-1];
            end
        end
    end

    // Next payload per stage; M2 captures the low-half partial product.
    always_comb begin
        stage_d[0] = '{meta: in_meta, a: in_a, b: in_b, acc: '0};
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
            if (k == 1) begin
                stage_d[k].acc = mul_lo_part(stage_q[0].a, stage_q[0].b);
            end
        end
    end

    // Payload registers; no reset, qualified by stage_valid.
    always_ff @(posedge clock) begin
        for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
        end
    end

    assign last = stage_q[STAGES-1];

    generate
        if (STAGES == 1) begin : g_single
            assign product = mul_lo_part(last.a, last.b) + mul_hi_part(last.a, last.b);
        end else begin : g_split
            assign product = last.acc + mul_hi_part(last.a, last.b);
        end
    endgenerate

    assign out_valid = stage_valid[STAGES-1];

    // Writeback request is all-zero when the last stage is empty.
    always_comb begin
        out_info = '0;
        if (stage_valid[STAGES-1]) begin
            out_info.instr_id = last.meta.instr_id;
            out_info.rd       = last.meta.rd;
            out_info.pc       = last.meta.pc;
            out_info.data     = product;
        end
    end

endmodule

// File: rtl/mul_top.sv
// Multiply stage between decode and writeback: a single operand-wait slot
// resolving sources from issue-time data or the ROB bypass, feeding mul_pipe.
module mul_top
    import mul_pkg::*;
#(
    parameter int MUL_STAGES = MUL_STAGES_DEFAULT  // legal range 1..8
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic reorder_buffer_full,
    mul_if.slave bus
);

    logic         h_valid;
    mul_request_t h_q;
    logic         src1_rdy;
    logic         src2_rdy;
    reg_data_t    src1_val;
    reg_data_t    src2_val;
    logic         issue;
    logic         accept;
    mul_meta_t    issue_meta;

    // A pending source is resolved by a same-cycle bypass hit.
    assign src1_rdy = h_q.src1_ready || bus.mul_src1_hit;
    assign src2_rdy = h_q.src2_ready || bus.mul_src2_hit;
    assign src1_val = h_q.src1_ready ? h_q.src1_data : bus.mul_src1_data;
    assign src2_val = h_q.src2_ready ? h_q.src2_data : bus.mul_src2_data;

    assign issue  = h_valid && src1_rdy && src2_rdy && !reorder_buffer_full && !flush;
    // Slot frees on the issue cycle, so back-to-back requests flow at 1/cycle.
    assign bus.mul_ready = !flush && (!h_valid || issue);
    assign accept = bus.req_valid && bus.mul_ready;

    // Lookup ids only matter for pending sources; zero otherwise.
    assign bus.mul_src1_id = (h_valid && !h_q.src1_ready) ? h_q.src1_id : '0;
    assign bus.mul_src2_id = (h_valid && !h_q.src2_ready) ? h_q.src2_id : '0;

    // Wait slot occupancy.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            h_valid <= 1'b0;
        end else if (accept) begin
            h_valid <= 1'b1;
        end else if (issue) begin
            h_valid <= 1'b0;
        end
    end

    // Wait slot contents: load on accept, otherwise latch bypass hits.
    always_ff @(posedge clock) begin
        if (accept) begin
            h_q <= bus.req_info;
        end else if (h_valid) begin
            if (!h_q.src1_ready && bus.mul_src1_hit) begin
                h_q.src1_data  <= bus.mul_src1_data;
                h_q.src1_ready <= 1'b1;
            end
            if (!h_q.src2_ready && bus.mul_src2_hit) begin
                h_q.src2_data  <= bus.mul_src2_data;
                h_q.src2_ready <= 1'b1;
            end
        end
    end

    // Metadata handed to M1 alongside the resolved operands.
    always_comb begin
        issue_meta          = '0;
        issue_meta.instr_id = h_q.instr_id;
        issue_meta.rd       = h_q.rd;
        issue_meta.pc       = h_q.pc;
    end

    mul_pipe #(
        .STAGES (MUL_STAGES)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (issue),
        .in_meta   (issue_meta),
        .in_a      (src1_val),
        .in_b      (src2_val),
        .out_valid (bus.mul_req_valid),
        .out_info  (bus.mul_req_info)
    );

endmodule

// File: tb/tb_mul_top.sv
// Directed bench for mul_top with MUL_STAGES=4.
module tb_mul_top;
    import mul_pkg::*;

    localparam int W = 6 + 5 + 32 + 32;  // {instr_id, rd, pc, data}

    logic clock = 1'b0;
    logic reset;
    logic flush;
    logic reorder_buffer_full;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    mul_if bus ();

    mul_top #(
        .MUL_STAGES (4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .flush               (flush),
        .reorder_buffer_full (reorder_buffer_full),
        .bus                 (bus)
    );

    // Clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic reg_data_t pc_of(input rob_id_t id);
        return 32'h0000_1000 | (32'(id) << 2);
    endfunction

    // Present one request for one cycle; if it is accepted and an output is
    // expected, queue the result due lat cycles after the accept cycle.
    task automatic send(input rob_id_t id, input reg_addr_t rd,
                        input reg_data_t a, input reg_data_t b,
                        input logic r1, input logic r2,
                        input rob_id_t s1id, input rob_id_t s2id,
                        input logic exp_ready, input logic expect_out,
                        input int lat, input reg_data_t exp_data);
        mul_request_t r;
        r            = '0;
        r.instr_id   = id;
        r.rd         = rd;
        r.pc         = pc_of(id);
        r.src1_data  = a;
        r.src2_data  = b;
        r.src1_ready = r1;
        r.src2_ready = r2;
        r.src1_id    = s1id;
        r.src2_id    = s2id;
        bus.req_info  = r;
        bus.req_valid = 1'b1;
        @(negedge clock);
        check("req_ready", 128'(bus.mul_ready), 128'(exp_ready));
        if (expect_out && bus.mul_ready) begin
            exp_q.push_back({id, rd, pc_of(id), exp_data});
            exp_cyc_q.push_back(cyc + lat);
        end
        step();
        bus.req_valid = 1'b0;
    endtask

    // Scoreboard: every output must match the head of the expected queue,
    // including the cycle it appears in.
    always @(negedge clock) begin
        logic [W-1:0] e;
        int           ec;
        if (!reset && bus.mul_req_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 128'(1), 128'(0));
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("out_data",     128'(bus.mul_req_info.data),       128'(e[31:0]));
                check("out_pc",       128'(bus.mul_req_info.pc),         128'(e[63:32]));
                check("out_rd",       128'(bus.mul_req_info.rd),         128'(e[68:64]));
                check("out_instr_id", 128'(bus.mul_req_info.instr_id),   128'(e[74:69]));
                check("out_xcpt",     128'(bus.mul_req_info.xcpt_valid), 128'(0));
                check("out_cycle",    128'(cyc),                         128'(ec));
            end
        end
    end

    initial begin
        reset               = 1'b1;
        flush               = 1'b0;
        reorder_buffer_full = 1'b0;
        bus.req_valid       = 1'b0;
        bus.req_info        = '0;
        bus.mul_src1_hit    = 1'b0;
        bus.mul_src2_hit    = 1'b0;
        bus.mul_src1_data   = '0;
        bus.mul_src2_data   = '0;

        // Reset values, during and just after reset.
        @(posedge clock);
        @(negedge clock);
        check("rst_ready_in",  128'(bus.mul_ready),     128'(1));
        check("rst_valid_in",  128'(bus.mul_req_valid), 128'(0));
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_ready",    128'(bus.mul_ready),     128'(1));
        check("rst_valid",    128'(bus.mul_req_valid), 128'(0));
        check("rst_info",     128'(bus.mul_req_info),  128'(0));
        check("rst_src1_id",  128'(bus.mul_src1_id),   128'(0));
        check("rst_src2_id",  128'(bus.mul_src2_id),   128'(0));
        step();

        // Single request, both operands ready: 7*6 after 5 cycles.
        send(6'd3, 5'd5, 32'd7, 32'd6, 1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'd42);
        repeat (8) step();

        // Four back-to-back ready requests.
        send(6'd4, 5'd1, 32'd3,          32'd4,      1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'd12);
        send(6'd5, 5'd2, 32'd100,        32'd200,    1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'd20000);
        send(6'd6, 5'd3, 32'h0000_FFFF,  32'h0000_FFFF, 1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'hFFFE_0001);
        send(6'd7, 5'd4, 32'h1234_5678,  32'h10,     1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'h2345_6780);
        repeat (8) step();

        // src2 pending on ROB id 9, hit three cycles later with 0xFFFF_FFFF.
        send(6'd10, 5'd7, 32'd2, 32'd0, 1'b1, 1'b0, '0, 6'd9, 1'b1, 1'b1, 8, 32'hFFFF_FFFE);
        repeat (3) begin
            @(negedge clock);
            check("wait_ready",   128'(bus.mul_ready),   128'(0));
            check("wait_src2_id", 128'(bus.mul_src2_id), 128'(9));
            step();
        end
        bus.mul_src2_hit  = 1'b1;
        bus.mul_src2_data = 32'hFFFF_FFFF;
        @(negedge clock);
        check("hit_ready", 128'(bus.mul_ready), 128'(1));
        step();
        bus.mul_src2_hit  = 1'b0;
        bus.mul_src2_data = '0;
        repeat (8) step();

        // Both pending: src1 hits first, src2 one cycle later -> 9*11.
        send(6'd11, 5'd8, 32'd0, 32'd0, 1'b0, 1'b0, 6'd4, 6'd7, 1'b1, 1'b1, 6, 32'd99);
        bus.mul_src1_hit  = 1'b1;
        bus.mul_src1_data = 32'd9;
        @(negedge clock);
        check("split_src1_id", 128'(bus.mul_src1_id), 128'(4));
        check("split_src2_id", 128'(bus.mul_src2_id), 128'(7));
        check("split_ready1",  128'(bus.mul_ready),   128'(0));
        step();
        bus.mul_src1_hit  = 1'b0;
        bus.mul_src1_data = '0;
        bus.mul_src2_hit  = 1'b1;
        bus.mul_src2_data = 32'd11;
        @(negedge clock);
        check("split_src2_id_b", 128'(bus.mul_src2_id), 128'(7));
        check("split_ready2",    128'(bus.mul_ready),   128'(1));
        step();
        bus.mul_src2_hit  = 1'b0;
        bus.mul_src2_data = '0;
        repeat (8) step();

        // ROB full for two cycles with a ready op in the slot.
        send(6'd12, 5'd9, 32'd9, 32'd9, 1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 7, 32'd81);
        reorder_buffer_full = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("robfull_ready", 128'(bus.mul_ready), 128'(0));
            step();
        end
        reorder_buffer_full = 1'b0;
        send(6'd13, 5'd10, 32'd5, 32'd5, 1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'd25);
        repeat (8) step();

        // Flush with the slot and M1..M3 occupied; none of these may retire.
        send(6'd20, 5'd11, 32'd1, 32'd1, 1'b1, 1'b1, '0, '0, 1'b1, 1'b0, 5, 32'd1);
        send(6'd21, 5'd12, 32'd2, 32'd2, 1'b1, 1'b1, '0, '0, 1'b1, 1'b0, 5, 32'd4);
        send(6'd22, 5'd13, 32'd3, 32'd3, 1'b1, 1'b1, '0, '0, 1'b1, 1'b0, 5, 32'd9);
        send(6'd23, 5'd14, 32'd4, 32'd4, 1'b1, 1'b1, '0, '0, 1'b1, 1'b0, 5, 32'd16);
        flush = 1'b1;
        send(6'd24, 5'd15, 32'd5, 32'd5, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0, 5, 32'd25);
        flush = 1'b0;
        @(negedge clock);
        check("post_flush_ready", 128'(bus.mul_ready), 128'(1));
        repeat (6) begin
            @(negedge clock);
            check("post_flush_valid", 128'(bus.mul_req_valid), 128'(0));
            step();
        end
        send(6'd25, 5'd16, 32'd11, 32'd13, 1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'd143);
        repeat (8) step();

        // Signed operands and high-bit overflow into discarded bits.
        send(6'd26, 5'd17, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'hFFFF_FFF1);
        send(6'd27, 5'd18, 32'h8000_0000, 32'd2, 1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 5, 32'h0000_0000);
        repeat (10) step();

        check("drain", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_top.md
# mul_top

Pipelined integer multiply stage between decode and writeback. Accepts one multiply per cycle from decode, holds it in a single operand-wait slot until both sources are resolved (issue-time value or ROB bypass), then runs it through a fixed-depth multiply pipeline. It emits the result to `wb_top` as `mul_req_valid` / `mul_req_info`. All in-flight work is killed on an exception flush.

## Interface
- Parameter `MUL_STAGES`, default 4: number of multiply pipeline registers (M1..M`MUL_STAGES`); legal range 1..8.
- Clocking: one clock; reset is synchronous and active-high.
- `clock`  in  1: core clock.
- `reset`  in  1: synchronous, active-high; clears all valids.
- `flush`  in  1: exception flush, the registered `xcpt_valid` from writeback; kills all work.
- `reorder_buffer_full`  in  1: when high, nothing issues into M1.
- `req_valid`  in  1: decode presents a multiply.
- `req_info`  in  `mul_request_t`: instr_id, rd, pc, src1/src2 data, src1/src2 ROB id, src1/src2 ready.
- `mul_ready`  out  1: the stage accepts `req_info` this cycle.
- `mul_src1_id`, `mul_src2_id`  out  `ROB_ID_RANGE`: bypass lookup ids, driven from the wait slot.
- `mul_src1_hit`, `mul_src2_hit`  in  1: bypass hit, same cycle as the id.
- `mul_src1_data`, `mul_src2_data`  in  `REG_FILE_DATA_RANGE`: bypass data.
- `mul_req_valid`  out  1: result valid to writeback.
- `mul_req_info`  out  `writeback_request_t`: instr_id, rd, pc, data, xcpt fields cleared.

## Operation
- Wait slot H: {valid, `mul_request_t`}.
  - Accept when `req_valid && mul_ready`; H loads at that clock edge.
- `mul_ready = !flush && (!H.valid || issue)`. Back-to-back accept is allowed on the issue cycle.
- Operand resolution, per source, while H.valid:
  - If ready, use the stored data.
  - Else drive its id on `mul_srcN_id`; a hit supplies `mul_srcN_data` for that cycle and the slot latches data plus ready.
  - Ids for sources that are already ready are don't-care. The bench masks them.
- `issue = H.valid && src1_eff_ready && src2_eff_ready && !reorder_buffer_full && !flush`.
  - Issue uses bypass data combinationally in the same cycle as the hit.
- M1 loads {instr_id, rd, pc, a, b} on issue. Each Mk advances unconditionally to Mk+1; the pipeline never stalls.
- Arithmetic:
  - Product = low 32 bits of a*b.
  - The full 64-bit product is split across stages; the low 32 bits are identical for signed and unsigned.
  - No overflow exception.
- Output: `mul_req_valid` = M`MUL_STAGES`.valid, and `mul_req_info` is built from that stage's fields.
- Flush: H.valid and every Mk.valid clear at the next edge. A request presented in the flush cycle is not accepted.
- Reset: identical to flush. Datapath registers need no reset.

## Timing
- Reset values: `mul_ready`=1, `mul_req_valid`=0, `mul_req_info`=0, `mul_src*_id`=0.
- Latency with operands ready and ROB not full:
  - Accept in cycle c, issue in c+1, `mul_req_valid` high in cycle c+1+`MUL_STAGES`.
  - Default: 5 cycles after acceptance.
- Throughput: 1 per cycle when operands are ready.
- Each cycle of operand wait or `reorder_buffer_full` adds exactly one cycle of latency.
- A hit on one source while the other is still pending: latch the hit source, keep waiting on the other.
- A flush in the same cycle as an issue wins: nothing enters M1.

## Structure
- Shared package `mul_pkg` (or `soc.vh` types):
  - `mul_request_t`
  - `MUL_STAGES` default
  - reuse of existing `writeback_request_t`, `ROB_ID_RANGE`, `REG_FILE_DATA_RANGE`, `REG_FILE_ADDR_RANGE`
- Sub-module `mul_pipe`: the parameterised valid/data shift pipeline with flush, instantiated once. Operand-wait logic stays in `mul_top`.

## Test plan
- Reset, then a single request {a=7, b=6, both ready, id=3, rd=5} -> `mul_req_valid` exactly 5 cycles later with data=42, instr_id=3, rd=5.
- Four back-to-back ready requests -> four consecutive valid outputs in order; `mul_ready` stays 1 throughout.
- src2 not ready (id=9); hit with data=0xFFFF_FFFF three cycles later, src1=2 -> result 0xFFFF_FFFE. Latency is 8; `mul_ready` is low while waiting.
- `reorder_buffer_full` held for 2 cycles with a ready op in H -> issue delayed 2 cycles; no output lost or duplicated.
- `flush` with H plus 3 pipeline stages valid -> no `mul_req_valid` afterwards. A request presented during flush is not accepted; the next post-flush request completes normally.
- Signed operands a=-3, b=5 -> data=0xFFFF_FFF1. a=0x8000_0000, b=2 -> data=0.
